// File: rtl/vector_pkg.sv
// Shared defaults, scan state encoding and raster helpers for the vector framebuffer arbiter.
package vector_pkg;

  localparam int VEC_ADDR_W = 16;
  localparam int VEC_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN_RD  = 2'd1,
    ST_SCAN_CAP = 2'd2,
    ST_SCAN_WB  = 2'd3
  } scan_state_t;

  function automatic logic pix_active(input logic [8:0] h, input logic [8:0] v);
    return (h < 9'd256) && (v < 9'd256);
  endfunction

endpackage

// File: rtl/vector_fb_clear.sv
// Clear-sweep address counter: walks the whole framebuffer one granted write at a time.
module vector_fb_clear #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              grant,
  output logic [ADDR_W-1:0] addr,
  output logic              busy
);

  // A restart wins over a same-cycle grant so the sweep always begins again at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      busy <= 1'b0;
    end else if (start) begin
      addr <= '0;
      busy <= 1'b1;
    end else if (grant && busy) begin
      addr <= addr + 1'b1;
      if (&addr) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out read/decay-writeback, clear sweep and line-drawer writes.
// States: IDLE grants clear/draw | SCAN_RD read addr | SCAN_CAP latch pixel | SCAN_WB decay writeback
module vector_fb_arbiter
  import vector_pkg::*;
#(
  parameter int ADDR_W      = VEC_ADDR_W,
  parameter int DATA_W      = VEC_DATA_W,
  parameter int DECAY_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [8:0]        hcnt,
  input  logic [8:0]        vcnt,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_data,
  output logic              draw_ack,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_wr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [DATA_W-1:0] pix_out,
  output logic              overrun
);

  scan_state_t       state, state_nxt;
  logic              ce_prev;
  logic              trigger;
  logic              active;
  logic              scan_go;
  logic              clear_grant;
  logic [ADDR_W-1:0] clear_addr;
  logic [ADDR_W-1:0] scan_addr;

  assign trigger = ce_pix & ~ce_prev;
  assign active  = pix_active(hcnt, vcnt);
  assign scan_go = trigger & active;

  vector_fb_clear #(
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clk  (clk),
    .reset(reset),
    .start(clear_start),
    .grant(clear_grant),
    .addr (clear_addr),
    .busy (clear_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Port outputs are combinational so a draw write lands in the cycle it is granted;
  // they are also forced idle while reset is held so no pending write completes.
  always_comb begin
    state_nxt   = state;
    fb_addr     = '0;
    fb_wr       = 1'b0;
    fb_wdata    = '0;
    draw_ack    = 1'b0;
    clear_grant = 1'b0;
    if (reset) begin
      unique case (state)
        ST_IDLE: begin
          if (scan_go) begin
            state_nxt = ST_SCAN_RD;
          end else if (clear_busy) begin
            clear_grant = 1'b1;
            fb_addr     = clear_addr;
            fb_wr       = 1'b1;
          end else if (draw_req) begin
            draw_ack = 1'b1;
            fb_addr  = draw_addr;
            fb_wdata = draw_data;
            fb_wr    = 1'b1;
          end
        end
        ST_SCAN_RD: begin
          fb_addr   = scan_addr;
          state_nxt = ST_SCAN_CAP;
        end
        ST_SCAN_CAP: state_nxt = ST_SCAN_WB;
        ST_SCAN_WB: begin
          if (DECAY_SHIFT != 0) begin
            fb_addr  = scan_addr;
            fb_wdata = pix_out >> DECAY_SHIFT;
            fb_wr    = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Scan address is latched at the trigger so read and writeback hit the same pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ce_prev   <= 1'b0;
      pix_out   <= '0;
      overrun   <= 1'b0;
      scan_addr <= '0;
    end else begin
      ce_prev <= ce_pix;
      if (trigger && state != ST_IDLE) overrun <= 1'b1;
      if (state == ST_IDLE && scan_go) scan_addr <= ADDR_W'({vcnt[7:0], hcnt[7:0]});
      if (state == ST_SCAN_CAP)                 pix_out <= fb_rdata;
      else if (state == ST_IDLE && trigger && !active) pix_out <= '0;
    end
  end

endmodule
